// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for a single FIFO write port.
// It grants one producer at a time for a burst and tracks free-slot credits so writes never overrun the FIFO.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_enb,
    input  logic                          fifo_rd_pop,
    output logic [2:0]                    grant_id,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          credits,
    output logic                          credit_err
);

    localparam int IDX_W  = 3;
    localparam int BEAT_W = 4;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        last_grant;
    logic [BEAT_W-1:0]       beat_cnt;

    logic                    hi_found;
    logic                    lo_found;
    logic [IDX_W-1:0]        hi_idx;
    logic [IDX_W-1:0]        lo_idx;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;

    logic                    valid_g;
    logic                    last_g;
    logic [DATA_WIDTH-1:0]   data_g;
    logic                    credits_ok;
    logic                    accept;
    logic                    beat_final;

    // Round-robin pick: lowest valid index above last_grant wins, else wrap to lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IDX_W'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
            end
        end
        sel_found = hi_found | lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        valid_g = 1'b0;
        last_g  = 1'b0;
        data_g  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                valid_g = req_valid[i];
                last_g  = req_last[i];
                data_g  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign credits_ok = (credits != '0);
    assign accept     = (state == BURST) && valid_g && credits_ok;
    assign beat_final = (beat_cnt == BEAT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A credit stall with valid held keeps the grant; only a dropped valid, last or burst cap releases it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (sel_found && credits_ok) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!valid_g || (accept && (last_g || beat_final))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == BURST);
        req_ready = '0;
        if ((state == BURST) && credits_ok) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (grant_id == IDX_W'(i)) && req_valid[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id   <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            if ((state == IDLE) && (state_next == BURST)) begin
                grant_id <= sel_idx;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if ((state == BURST) && (state_next == IDLE)) begin
                last_grant <= grant_id;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_enb  <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_enb <= accept;
            if (accept) begin
                fifo_wr_data <= data_g;
            end
        end
    end

    // Credits count writes in flight, so the lagging FIFO full flag is never needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits    <= CNT_WIDTH'(DEPTH);
            credit_err <= 1'b0;
        end else begin
            credit_err <= 1'b0;
            case ({accept, fifo_rd_pop})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CNT_WIDTH'(DEPTH)) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + 1'b1;
                    end
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port between `NUM_REQ` producers using a valid/ready handshake per producer. It grants one producer at a time for a burst and registers the selected beat onto the FIFO write port. It keeps its own free-slot credit count, so a write is never issued into a full FIFO and `fifo_overrun` cannot fire. It sits directly in front of the `fifo` write side. The consumer of the FIFO reports accepted reads back to it.

## Interface
- `NUM_REQ`, 4, number of producers (2..8)
- `DATA_WIDTH`, 8, beat width; matches the FIFO
- `DEPTH`, 8, FIFO depth; this is the initial credit value
- `CNT_WIDTH`, 4, credit counter width, log2(DEPTH)+1
- `MAX_BURST`, 4, maximum beats per grant (1..15)

- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-producer beat valid
- `req_last`  in  NUM_REQ  per-producer last-beat-of-burst marker
- `req_data`  in  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `req_ready`  out  NUM_REQ  per-producer beat accepted when high together with valid
- `fifo_wr_data`  out  DATA_WIDTH  to the FIFO `wr_data`; registered
- `fifo_wr_enb`  out  1  to the FIFO `wr_enb`; registered
- `fifo_rd_pop`  in  1  one pulse per read the FIFO accepts (rd_enb & !fifo_empty)
- `grant_id`  out  3  index of the current or last grantee; registered
- `busy`  out  1  high in BURST
- `credits`  out  CNT_WIDTH  free FIFO slots, counting writes already in flight
- `credit_err`  out  1  one-cycle pulse when a pop arrives while credits==DEPTH

## Operation
- FSM has two states: IDLE and BURST.
- **IDLE:** if any `req_valid` is high and credits>0:
  - Select the first valid index, searching upward from `last_grant+1` mod NUM_REQ.
  - Load `grant_id`, clear `beat_cnt`, go to BURST.
  - Otherwise stay in IDLE.
- **BURST, handshake:**
  - `req_ready[grant_id]` = `req_valid[grant_id]` & (credits>0). It is combinational from registered state.
  - All other `req_ready` bits are 0.
  - `req_ready` is always 0 in IDLE.
- **Accept:** an accept is valid & ready on the granted producer. On an accept:
  - `fifo_wr_data` <= that producer's data and `fifo_wr_enb` <= 1 on the next edge.
  - `beat_cnt` increments.
  - credits decrements.
- `fifo_wr_enb` is 0 in every cycle without an accept.
- **BURST exit:** go to IDLE and set `last_grant` <= `grant_id` on any of these:
  - an accept with `req_last`=1;
  - an accept that brings `beat_cnt` to MAX_BURST;
  - a cycle where `req_valid[grant_id]`=0.
- When credits==0 and valid is held, the FSM stays in BURST with ready low. This stall keeps the grant.
- **Credits:**
  - An accept alone gives −1.
  - `fifo_rd_pop` alone gives +1.
  - Both in the same cycle leave credits unchanged.
  - A pop while credits==DEPTH with no same-cycle accept leaves credits at DEPTH and pulses `credit_err`.
  - Credits never go below 0, since ready is gated.
- Round-robin is fair: a continuously valid producer waits at most NUM_REQ−1 grants.

## Timing
- **Reset values:**
  - state=IDLE, `last_grant`=NUM_REQ−1 (producer 0 has first priority);
  - `grant_id`=0, `busy`=0, `req_ready`=0;
  - `fifo_wr_enb`=0, `fifo_wr_data`=0;
  - credits=DEPTH, `credit_err`=0.
- Reset can be asserted mid-burst. It aborts the burst immediately and any beat not yet registered is dropped.
- Arbitration latency: valid seen in IDLE at cycle T gives BURST and ready at T+1. The first accept is at T+1 at the earliest.
- Write latency: an accept at cycle T gives `fifo_wr_enb`=1 at T+1, with data stable for that cycle.
- Throughput is one beat per cycle within a burst.
- There is one IDLE bubble cycle between bursts.
- A credit change is visible on `credits` the cycle after its cause.
- Back-pressure does not depend on the FIFO's `fifo_full` flag, which lags by one cycle. Credits alone gate writes.

## Test plan
- **Reset and single beat:** reset, then producer 2 valid with data 0xA5 and last=1 at cycle 1.
  - Required: ready[2] at cycle 2, `fifo_wr_enb`/0xA5 at cycle 3, credits 8→7, `grant_id`=2.
- **Round-robin:** all 4 producers valid with last=1, repeated.
  - Required: grant order 0,1,2,3,0, one beat each, with a bubble between grants.
- **MAX_BURST cut:** producer 1 sends 6 beats with no last, values 0x10..0x15.
  - Required: 4 writes 0x10..0x13, then IDLE. A re-grant to 1 (if it is the only requester) writes 0x14, 0x15.
- **Credit stall:** no pops, producer 0 streams 10 beats.
  - Required: 8 accepted and credits=0, then ready stays low with `busy` held.
  - Next: one `fifo_rd_pop` gives exactly one more accept.
- **Simultaneous accept and pop at credits=3:** credits stay at 3.
- **Pop at credits=8:** gives a `credit_err` pulse and credits stay at 8.
- **Reset mid-burst:** assert rst during the 2nd beat of a 4-beat burst.
  - Required: every output takes its reset value immediately, credits=8, and the next grant goes to producer 0.
